piso_frame_tx: RTL and testbench

Parallel-in, serial-out frame transmitter: the sending end of the team's bit-serial link, whose receive side is the D-flip-flop capture/shift chain.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Serialises the word as start bit, data bits LSB-first, optional parity bit and stop bit.
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between a parallel producer (register file / datapath) and the single-wire serial line.

---
 rtl/piso_frame_tx_pkg.sv | 30 +++
 rtl/piso_frame_tx_if.sv | 37 +++
 rtl/piso_frame_tx_bit_timer.sv | 46 ++++
 rtl/piso_frame_tx.sv | 155 +++++++++++++++
 tb/tb_piso_frame_tx.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_frame_tx_pkg.sv
// ---------------------------------------------------------------------------
// piso_frame_tx_pkg
//
// Purpose:
//   Shared definitions for the parallel-in / serial-out frame transmitter.
//   Holds the frame state encoding and the helper that sizes the bit timer
//   and bit-index counters.
//
// Contents:
//   state_t  - 3-bit frame state encoding (IDLE=0, START=1, DATA=2,
//              PARITY=3, STOP=4)
//   cnt_w()  - counter width for a modulus n (clog2, never below one bit)
// ---------------------------------------------------------------------------
package piso_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // A modulus of 1 still needs a 1-bit register so the counter has a
    // legal, non-zero width.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : piso_frame_tx_pkg

// File: rtl/piso_frame_tx_if.sv
// ---------------------------------------------------------------------------
// piso_frame_tx_if
//
// Purpose:
//   Parallel word handshake between a producer (register file / datapath)
//   and the serial frame transmitter.
//
// Signals:
//   in_data   WIDTH  word to transmit
//   in_valid  1      producer presents a word on in_data
//   in_ready  1      transmitter accepts a word this cycle
//
// Modports:
//   master - producer side (drives in_data / in_valid)
//   slave  - transmitter side (drives in_ready)
// ---------------------------------------------------------------------------
interface piso_frame_tx_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface : piso_frame_tx_if

// File: rtl/piso_frame_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// piso_frame_tx_bit_timer
//
// Purpose:
//   Bit-period counter for the serial transmitter. Counts
//   0..CLKS_PER_BIT-1 and wraps; tick is high during the last cycle of each
//   bit period, i.e. the cycle whose closing edge is a bit boundary.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-low reset (count returns to 0)
//   clr   in   hold the count at 0 (used while idle so a new frame starts
//              on a fresh bit period)
//   tick  out  count == CLKS_PER_BIT-1
// ---------------------------------------------------------------------------
module piso_frame_tx_bit_timer
    import piso_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            TW      = cnt_w(CLKS_PER_BIT);
    localparam logic [TW-1:0] CNT_MAX = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    // With CLKS_PER_BIT == 1 the count sits at 0 and tick is permanently
    // high, giving one bit per clock.
    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : piso_frame_tx_bit_timer

// File: rtl/piso_frame_tx.sv
// ---------------------------------------------------------------------------
// piso_frame_tx
//
// Purpose:
//   Parallel-in, serial-out frame transmitter for the bit-serial link.
//   Accepts one WIDTH-bit word per valid/ready handshake and sends it as
//     start(0) | data LSB-first | [parity] | stop(1)
//   with every bit held for CLKS_PER_BIT clocks. The line idles high.
//
// Parameters:
//   WIDTH         data bits per frame (1..32)
//   CLKS_PER_BIT  clocks per serial bit (>= 1)
//   PARITY_EN     1 = insert a parity bit after the data bits
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-low reset
//   bus      if   slave side of piso_frame_tx_if (in_data/in_valid/in_ready)
//   ser_out  out  serial line (registered, idles high)
//   busy     out  a frame is in progress
//   done     out  one-cycle pulse in the first idle cycle after a stop bit
// ---------------------------------------------------------------------------
module piso_frame_tx
    import piso_frame_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic            clk,
    input  logic            rst,
    piso_frame_tx_if.slave  bus,
    output logic            ser_out,
    output logic            busy,
    output logic            done
);

    localparam int               IDX_W    = cnt_w(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0);
    localparam logic             HAS_PAR  = (PARITY_EN != 0);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   shift_nxt;
    logic               parity_bit;
    logic               parity_nxt;
    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   bit_idx_nxt;
    logic               ser_nxt;
    logic               done_nxt;
    logic               tick;
    logic               idle;

    assign idle         = (state == ST_IDLE);
    assign bus.in_ready = idle;
    assign busy         = !idle;

    // The timer is held at zero while idle, so the accept edge always
    // starts the start bit on a full bit period.
    piso_frame_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (idle),
        .tick (tick)
    );

    // Next-state, datapath update and next serial level.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        parity_nxt  = parity_bit;
        bit_idx_nxt = bit_idx;
        done_nxt    = 1'b0;
        ser_nxt     = 1'b1;

        unique case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nxt   = ST_START;
                    shift_nxt   = bus.in_data;
                    parity_nxt  = (^bus.in_data) ^ ODD_BIT;
                    bit_idx_nxt = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    // Shifting on the last bit too is harmless: the
                    // register is not read again until the next accept.
                    shift_nxt = shift_reg >> 1;
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // ser_out is registered, so its next value follows the next state.
        unique case (state_nxt)
            ST_START:  ser_nxt = 1'b0;
            ST_DATA:   ser_nxt = shift_nxt[0];
            ST_PARITY: ser_nxt = parity_nxt;
            default:   ser_nxt = 1'b1;
        endcase
    end

    // Control registers: reset returns the line to idle-high and drops any
    // pending done, which is how a mid-frame reset aborts the frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            ser_out <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_idx_nxt;
            ser_out <= ser_nxt;
            done    <= done_nxt;
        end
    end

    // Data registers: only loaded on accept, so no reset is needed.
    always_ff @(posedge clk) begin
        shift_reg  <= shift_nxt;
        parity_bit <= parity_nxt;
    end

endmodule : piso_frame_tx

// File: tb/tb_piso_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_frame_tx
//
// Three transmitters (no parity, even parity, odd parity; WIDTH=8,
// CLKS_PER_BIT=4) share one stimulus. A frame-level reference model tracks,
// per instance, whether a frame is active, how many cycles it has run and
// the word it carries; the expected line level is the frame bit at
// cycle / CLKS_PER_BIT. Every output is compared each cycle, plus directed
// checks at the interesting cycles.
// ---------------------------------------------------------------------------
module tb_piso_frame_tx;

    localparam int W = 8;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] drv_data;
    logic       drv_valid;
    bit         chk_en = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    piso_frame_tx_if #(.WIDTH(W)) ifc0 ();
    piso_frame_tx_if #(.WIDTH(W)) ifc1 ();
    piso_frame_tx_if #(.WIDTH(W)) ifc2 ();

    assign ifc0.in_data  = drv_data;
    assign ifc1.in_data  = drv_data;
    assign ifc2.in_data  = drv_data;
    assign ifc0.in_valid = drv_valid;
    assign ifc1.in_valid = drv_valid;
    assign ifc2.in_valid = drv_valid;

    logic [2:0] ser;
    logic [2:0] bsy;
    logic [2:0] dn;
    logic [2:0] rdy;

    assign rdy = {ifc2.in_ready, ifc1.in_ready, ifc0.in_ready};

    piso_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .bus(ifc0), .ser_out(ser[0]), .busy(bsy[0]), .done(dn[0]));
    piso_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .bus(ifc1), .ser_out(ser[1]), .busy(bsy[1]), .done(dn[1]));
    piso_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst(rst), .bus(ifc2), .ser_out(ser[2]), .busy(bsy[2]), .done(dn[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pen(input int i);
        return (i != 0) ? 1 : 0;
    endfunction

    function automatic int podd(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    function automatic int flen(input int i);
        return (2 + W + pen(i)) * C;
    endfunction

    // Level of frame bit k: start, data LSB-first, optional parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input int p, input int o, input int k);
        if (k == 0) return 1'b0;
        if (k <= W) return d[k-1];
        if (p != 0 && k == W + 1) return (^d) ^ (o != 0);
        return 1'b1;
    endfunction

    bit         m_act  [3] = '{0, 0, 0};
    bit         m_done [3] = '{0, 0, 0};
    int         m_cyc  [3] = '{0, 0, 0};
    logic [7:0] m_dat  [3] = '{8'h00, 8'h00, 8'h00};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin : model_upd
            bit         na;
            bit         nd;
            int         nc;
            logic [7:0] ndat;
            na   = m_act[i];
            nd   = 1'b0;
            nc   = m_cyc[i];
            ndat = m_dat[i];
            if (!rst) begin
                na = 1'b0;
            end else if (m_act[i]) begin
                nc = m_cyc[i] + 1;
                if (nc == flen(i)) begin
                    na = 1'b0;
                    nd = 1'b1;
                end
            end else if (drv_valid) begin
                na   = 1'b1;
                nc   = 0;
                ndat = drv_data;
            end
            m_act[i]  <= na;
            m_done[i] <= nd;
            m_cyc[i]  <= nc;
            m_dat[i]  <= ndat;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic es;
                es = m_act[i] ? frame_bit(m_dat[i], pen(i), podd(i), m_cyc[i] / C) : 1'b1;
                check($sformatf("ser%0d", i),   32'(ser[i]), 32'(es));
                check($sformatf("busy%0d", i),  32'(bsy[i]), 32'(m_act[i]));
                check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(!m_act[i]));
                check($sformatf("done%0d", i),  32'(dn[i]),  32'(m_done[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge of cycle 1 (start bit visible).
    task automatic send_one(input logic [7:0] d);
        drv_valid = 1'b1;
        drv_data  = d;
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            if (!m_act[0] && !m_act[1] && !m_act[2]) break;
            @(negedge clk);
        end
        if (k == 400) check("idle_timeout", 32'd1, 32'd0);
        tick_n(2);
    endtask

    initial begin
        rst       = 1'b0;
        drv_valid = 1'b1;
        drv_data  = 8'hA5;

        // Reset held with in_valid high: nothing may start.
        @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ser",   32'(ser[0]), 32'd1);
            check("rst_ready", 32'(rdy[0]), 32'd1);
            check("rst_busy",  32'(bsy[0]), 32'd0);
            check("rst_done",  32'(dn[0]),  32'd0);
            if (i < 2) @(negedge clk);
        end
        rst       = 1'b1;
        drv_valid = 1'b0;
        tick_n(2);

        // Basic and parity frames of 0xA5.
        send_one(8'hA5);
        check("a5_start", 32'(ser[0]), 32'd0);
        check("a5_ready", 32'(rdy[0]), 32'd0);
        tick_n(39);
        check("a5_stop",     32'(ser[0]), 32'd1);
        check("a5_done_c40", 32'(dn[0]),  32'd0);
        check("par_even",    32'(ser[1]), 32'd0);
        check("par_odd",     32'(ser[2]), 32'd1);
        tick_n(1);
        check("a5_done_c41", 32'(dn[0]),  32'd1);
        check("a5_ready41",  32'(rdy[0]), 32'd1);
        tick_n(3);
        check("par_done_c44", 32'(dn[1]), 32'd0);
        tick_n(1);
        check("par_done_c45", 32'(dn[1]), 32'd1);
        check("odd_done_c45", 32'(dn[2]), 32'd1);
        wait_idle();

        // Back-to-back with in_valid held.
        drv_valid = 1'b1;
        drv_data  = 8'h01;
        @(negedge clk);
        drv_data  = 8'hFF;
        tick_n(40);
        check("b2b_done",  32'(dn[0]),  32'd1);
        check("b2b_ready", 32'(rdy[0]), 32'd1);
        check("b2b_idle",  32'(ser[0]), 32'd1);
        @(negedge clk);
        check("b2b_start2", 32'(ser[0]), 32'd0);
        check("b2b_busy2",  32'(bsy[0]), 32'd1);
        drv_valid = 1'b0;
        wait_idle();

        // Reset during the third data bit (cycles 13..16).
        send_one(8'h3C);
        tick_n(13);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ser",  32'(ser[0]), 32'd1);
        check("abort_busy", 32'(bsy[0]), 32'd0);
        check("abort_done", 32'(dn[0]),  32'd0);
        rst = 1'b1;
        tick_n(3);
        send_one(8'h3C);
        wait_idle();

        // in_data changes right after acceptance.
        send_one(8'h00);
        drv_data = 8'hFF;
        tick_n(4);
        for (int b = 0; b < 8; b++) begin
            check($sformatf("stab_bit%0d", b), 32'(ser[0]), 32'd0);
            tick_n(4);
        end
        wait_idle();

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            drv_valid = ($urandom_range(0, 2) == 0);
            drv_data  = 8'($urandom);
            rst       = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        rst       = 1'b1;
        drv_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_piso_frame_tx
